// File: rtl/hot_water_arbiter_pkg.sv
// hot_water_arbiter_pkg: shared types and default constants for the hot-water valve arbiter.
//   Holds the arbiter state enum, the default parameter values and the 3-bit owner index width.
package hwa_pkg;
    localparam int N_MACH_D    = 4;
    localparam int MAX_GRANT_D = 64;
    localparam int GAP_D       = 2;
    localparam int ID_W        = 3;
    typedef enum logic [1:0] {ST_IDLE, ST_HOLD, ST_GAP} state_t;
endpackage

// File: rtl/hot_water_arbiter_if.sv
// hot_water_arbiter_if: washer-side bundle of the hot-water valve arbiter.
//   Washer controllers (master) drive power/req/done.
//   The arbiter (slave) drives grant, valve_hot, owner_id, grant_left and overrun.
interface hot_water_arbiter_if import hwa_pkg::*; #(parameter int N_MACH = N_MACH_D);
    logic              power;
    logic [N_MACH-1:0] req;
    logic [N_MACH-1:0] done;
    logic [N_MACH-1:0] grant;
    logic              valve_hot;
    logic [ID_W-1:0]   owner_id;
    logic [7:0]        grant_left;
    logic [N_MACH-1:0] overrun;
    modport master (output power, req, done, input grant, valve_hot, owner_id, grant_left, overrun);
    modport slave (input power, req, done, output grant, valve_hot, owner_id, grant_left, overrun);
endinterface

// File: rtl/hot_water_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector.
//   req  in  N_MACH  effective requests
//   ptr  in  ID_W    first index to consider (wraps)
//   pick out N_MACH  one-hot winner, 0 when no request
//   idx  out ID_W    winner index, 0 when no request
//   any  out 1       at least one request
module rr_pick import hwa_pkg::*; #(
    parameter int N_MACH = N_MACH_D
) (
    input  logic [N_MACH-1:0] req,
    input  logic [ID_W-1:0]   ptr,
    output logic [N_MACH-1:0] pick,
    output logic [ID_W-1:0]   idx,
    output logic              any
);
    logic [N_MACH-1:0] rot;
    logic [ID_W:0]     sum;
    // Rotate so bit 0 is the requester at ptr; the lowest set bit then wins.
    assign rot = N_MACH'({req, req} >> ptr);
    assign any = |req;
    always_comb begin
        sum = '0;
        for (int k = N_MACH - 1; k >= 0; k--)
            if (rot[k]) sum = {1'b0, ptr} + (ID_W+1)'(k);
    end
    assign idx  = ID_W'(sum >= (ID_W+1)'(N_MACH) ? sum - (ID_W+1)'(N_MACH) : sum);
    assign pick = any ? N_MACH'(1) << idx : '0;
endmodule

// File: rtl/hot_water_arbiter.sv
// hot_water_arbiter: round-robin owner of one shared hot-water inlet valve among N_MACH washers.
//   clk  in  1  system clock, rising edge
//   rst  in  1  asynchronous active-low reset
//   bus  hot_water_arbiter_if.slave: power/req/done in; grant/valve_hot/owner_id/grant_left/overrun out
//   Define HWA_LOCKOUT_EN to mask a washer that overran until it drops req for a cycle.
//   The valve stays closed for exactly GAP cycles between owners: the release cycle counts as
//   the first closed cycle, so the gap counter is loaded with GAP-1 on release.
module hot_water_arbiter import hwa_pkg::*; #(
    parameter int N_MACH    = N_MACH_D,
    parameter int MAX_GRANT = MAX_GRANT_D,
    parameter int GAP       = GAP_D
) (
    input logic clk,
    input logic rst,
    hot_water_arbiter_if.slave bus
);
    if (MAX_GRANT < 1 || MAX_GRANT > 255 || N_MACH < 2 || N_MACH > 8 || GAP < 1 || GAP > 15) begin : g_bad_cfg
        $error("hot_water_arbiter: parameter out of range");
    end
    localparam logic [ID_W-1:0] LAST = ID_W'(N_MACH - 1);
    state_t            state, state_n;
    logic [N_MACH-1:0] grant, grant_n, overrun, overrun_n, req_eff, pick;
    logic [ID_W-1:0]   owner, owner_n, rr_ptr, rr_n, pick_idx;
    logic [7:0]        left, left_n, gap_cnt, gap_n;
    logic              valve, pick_any, own_req, own_done, timeout;
`ifdef HWA_LOCKOUT_EN
    logic [N_MACH-1:0] lock;
    assign req_eff = bus.req & ~lock;
    always_ff @(posedge clk or negedge rst)
        if (!rst) lock <= '0;
        else lock <= (lock & bus.req) | overrun_n;
`else
    assign req_eff = bus.req;
`endif
    rr_pick #(.N_MACH(N_MACH)) u_pick (.req(req_eff), .ptr(rr_ptr), .pick(pick), .idx(pick_idx), .any(pick_any));
    // grant is one-hot, so masking with it selects the owner's lines without an index.
    assign own_req  = |(bus.req & grant);
    assign own_done = |(bus.done & grant);
    assign timeout  = own_req && !own_done && left == 8'd1;
    always_comb begin
        state_n   = state;
        grant_n   = grant;
        owner_n   = owner;
        left_n    = left;
        rr_n      = rr_ptr;
        gap_n     = gap_cnt;
        overrun_n = '0;
        if (!bus.power) begin
            state_n = ST_IDLE;
            grant_n = '0;
            left_n  = '0;
            gap_n   = '0;
        end else begin
            case (state)
                ST_IDLE: if (pick_any) begin
                    state_n = ST_HOLD;
                    grant_n = pick;
                    owner_n = pick_idx;
                    left_n  = 8'(MAX_GRANT);
                end
                ST_HOLD: if (!own_req || own_done || left == 8'd1) begin
                    state_n   = GAP > 1 ? ST_GAP : ST_IDLE;
                    grant_n   = '0;
                    left_n    = '0;
                    rr_n      = owner == LAST ? '0 : owner + ID_W'(1);
                    gap_n     = 8'(GAP - 1);
                    overrun_n = timeout ? grant : '0;
                end else begin
                    left_n = left - 8'd1;
                end
                default: begin
                    gap_n = gap_cnt - 8'd1;
                    if (gap_cnt <= 8'd1) state_n = ST_IDLE;
                end
            endcase
        end
    end
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state   <= ST_IDLE;
            grant   <= '0;
            valve   <= 1'b0;
            owner   <= '0;
            left    <= '0;
            overrun <= '0;
            rr_ptr  <= '0;
            gap_cnt <= '0;
        end else begin
            state   <= state_n;
            grant   <= grant_n;
            valve   <= |grant_n;
            owner   <= owner_n;
            left    <= left_n;
            overrun <= overrun_n;
            rr_ptr  <= rr_n;
            gap_cnt <= gap_n;
        end
    assign bus.grant      = grant;
    assign bus.valve_hot  = valve;
    assign bus.owner_id   = owner;
    assign bus.grant_left = left;
    assign bus.overrun    = overrun;
endmodule

// File: tb/tb_hot_water_arbiter.sv
// tb_hot_water_arbiter: directed self-checking bench for hot_water_arbiter (N_MACH=4, MAX_GRANT=64, GAP=2).
module tb_hot_water_arbiter;
    import hwa_pkg::*;
    logic clk = 1'b0;
    logic rst;
    int vectors = 0;
    int miscompares = 0;
    logic [3:0] exp_g;
    always #5 clk = ~clk;
    hot_water_arbiter_if #(.N_MACH(4)) bus ();
    hot_water_arbiter #(.N_MACH(4), .MAX_GRANT(64), .GAP(2)) dut (.clk(clk), .rst(rst), .bus(bus));
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic chk_out(input string tag, input logic [3:0] g, input logic [7:0] gl, input logic [3:0] ov);
        chk({tag, ".grant"}, 32'(bus.grant), 32'(g));
        chk({tag, ".valve"}, 32'(bus.valve_hot), 32'(|g));
        chk({tag, ".left"}, 32'(bus.grant_left), 32'(gl));
        chk({tag, ".ovr"}, 32'(bus.overrun), 32'(ov));
    endtask
    initial begin
        rst = 1'b0;
        bus.power = 1'b1;
        bus.req = 4'b0101;
        bus.done = 4'b0000;
        step(2);
        chk_out("reset", 4'b0000, 8'd0, 4'b0000);
        chk("reset.owner", 32'(bus.owner_id), 32'd0);
        rst = 1'b1;
        step(1);
        chk_out("first_grant", 4'b0001, 8'd64, 4'b0000);
        chk("first_grant.owner", 32'(bus.owner_id), 32'd0);
        bus.done = 4'b0010;
        step(1);
        chk_out("nonowner_done", 4'b0001, 8'd63, 4'b0000);
        bus.done = 4'b0001;
        step(1);
        bus.done = 4'b0000;
        chk_out("done_release", 4'b0000, 8'd0, 4'b0000);
        step(1);
        chk_out("gap2", 4'b0000, 8'd0, 4'b0000);
        step(1);
        chk_out("rr_skip1", 4'b0100, 8'd64, 4'b0000);
        chk("rr_skip1.owner", 32'(bus.owner_id), 32'd2);
        step(63);
        chk_out("hold_last", 4'b0100, 8'd1, 4'b0000);
        step(1);
        chk_out("timeout", 4'b0000, 8'd0, 4'b0100);
        step(1);
        chk_out("ovr_pulse_end", 4'b0000, 8'd0, 4'b0000);
        step(1);
        chk_out("after_timeout", 4'b0001, 8'd64, 4'b0000);
        bus.req = 4'b0100;
        step(1);
        chk_out("req_drop_release", 4'b0000, 8'd0, 4'b0000);
        step(2);
`ifdef HWA_LOCKOUT_EN
        exp_g = 4'b0000;
`else
        exp_g = 4'b0100;
`endif
        chk_out("stuck_washer", exp_g, exp_g != 0 ? 8'd64 : 8'd0, 4'b0000);
        bus.req = 4'b0000;
        step(4);
        chk_out("all_idle", 4'b0000, 8'd0, 4'b0000);
        bus.req = 4'b1000;
        step(1);
        chk_out("single_req3", 4'b1000, 8'd64, 4'b0000);
        bus.req = 4'b1111;
        bus.done = 4'b1000;
        step(1);
        bus.done = 4'b0000;
        chk_out("done_no_ovr", 4'b0000, 8'd0, 4'b0000);
        step(2);
        for (int k = 0; k < 6; k++) begin
            exp_g = 4'b0001 << (k % 4);
            chk_out("rr_cycle", exp_g, 8'd64, 4'b0000);
            if (k < 5) begin
                step(4);
                chk("rr_cycle.left4", 32'(bus.grant_left), 32'd60);
                bus.done = exp_g;
                step(1);
                bus.done = 4'b0000;
                chk_out("rr_gap_a", 4'b0000, 8'd0, 4'b0000);
                step(1);
                chk_out("rr_gap_b", 4'b0000, 8'd0, 4'b0000);
                step(1);
            end
        end
        chk("pre_power.owner", 32'(bus.owner_id), 32'd1);
        bus.power = 1'b0;
        step(1);
        chk_out("power_off", 4'b0000, 8'd0, 4'b0000);
        chk("power_off.owner", 32'(bus.owner_id), 32'd1);
        step(2);
        chk_out("power_off_hold", 4'b0000, 8'd0, 4'b0000);
        bus.power = 1'b1;
        step(1);
        chk_out("power_resume", 4'b0010, 8'd64, 4'b0000);
        chk("power_resume.owner", 32'(bus.owner_id), 32'd1);
        step(1);
        chk("pre_rst.left", 32'(bus.grant_left), 32'd63);
        #2;
        rst = 1'b0;
        #1;
        chk_out("async_rst", 4'b0000, 8'd0, 4'b0000);
        chk("async_rst.owner", 32'(bus.owner_id), 32'd0);
        step(1);
        chk_out("rst_no_ovr", 4'b0000, 8'd0, 4'b0000);
        rst = 1'b1;
        step(1);
        chk_out("post_rst_grant", 4'b0001, 8'd64, 4'b0000);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
